router_port_arbiter: RTL and testbench

Per-output-port round-robin arbiter for the 16x16 packet router. Each input-port driver requests a destination port by address. The arbiter grants exclusive ownership of that output until the driver releases it or a hold-limit watchdog expires. It sits between the per-input frame drivers and the router's serial din/frame_n/valid_n lanes, so that no two drivers frame the same destination at once.

---
 rtl/router_port_arbiter_if.sv | 24 ++
 rtl/router_port_arbiter.sv | 110 +++++++++++
 tb/tb_router_port_arbiter.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/router_port_arbiter_if.sv
// Request/grant bundle between the per-input frame drivers and the output-port arbiter.
// The master side is the driver population; the slave side is the arbiter.
interface router_port_arbiter_if #(
  parameter int unsigned NUM_PORTS = 16,
  parameter int unsigned ADDR_W    = 4
);
  logic [NUM_PORTS-1:0]        req;
  logic [NUM_PORTS*ADDR_W-1:0] req_da;
  logic [NUM_PORTS-1:0]        rel;
  logic [NUM_PORTS-1:0]        gnt;
  logic [NUM_PORTS-1:0]        out_busy;
  logic [NUM_PORTS*ADDR_W-1:0] out_owner;
  logic [NUM_PORTS-1:0]        timeout;

  modport master (
    output req, req_da, rel,
    input  gnt, out_busy, out_owner, timeout
  );

  modport slave (
    input  req, req_da, rel,
    output gnt, out_busy, out_owner, timeout
  );
endinterface

// File: rtl/router_port_arbiter.sv
// Per-output round-robin arbiter: each output grants one input at a time until release
// or until the hold-limit watchdog reclaims it.
module router_port_arbiter #(
  parameter int unsigned NUM_PORTS  = 16,
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned HOLD_LIMIT = 4096
) (
  input logic                  clock,
  input logic                  reset,
  router_port_arbiter_if.slave bus
);

  localparam int unsigned CntW = (HOLD_LIMIT > 0) ? $clog2(HOLD_LIMIT + 1) : 1;
  localparam logic [CntW-1:0] HoldMax = CntW'(HOLD_LIMIT);

  typedef enum logic {StIdle, StOwned} state_e;

  state_e              state_q [NUM_PORTS];
  state_e              state_d [NUM_PORTS];
  logic [ADDR_W-1:0]   owner_q [NUM_PORTS];
  logic [ADDR_W-1:0]   owner_d [NUM_PORTS];
  logic [ADDR_W-1:0]   ptr_q   [NUM_PORTS];
  logic [ADDR_W-1:0]   ptr_d   [NUM_PORTS];
  logic [CntW-1:0]     cnt_q   [NUM_PORTS];
  logic [CntW-1:0]     cnt_d   [NUM_PORTS];
  logic [NUM_PORTS-1:0] gnt_q, gnt_d;
  logic [NUM_PORTS-1:0] timeout_q, timeout_d;

  logic        found;
  int unsigned idx;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt_q;
    timeout_d = '0;
    found     = 1'b0;
    idx       = 0;

    for (int o = 0; o < NUM_PORTS; o++) begin
      if (state_q[o] == StIdle) begin
        found = 1'b0;
        // Rotating scan from ptr; an input already holding a grant is never a candidate.
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
          idx = (32'(ptr_q[o]) + k) % NUM_PORTS;
          if (!found && bus.req[idx] && !gnt_q[idx] &&
              (bus.req_da[idx*ADDR_W +: ADDR_W] == ADDR_W'(o))) begin
            found      = 1'b1;
            state_d[o] = StOwned;
            owner_d[o] = ADDR_W'(idx);
            ptr_d[o]   = ADDR_W'((idx + 1) % NUM_PORTS);
            cnt_d[o]   = CntW'(1);
            gnt_d[idx] = 1'b1;
          end
        end
      end else begin
        // Release beats watchdog expiry when both land in the same cycle.
        if (bus.rel[owner_q[o]]) begin
          state_d[o]          = StIdle;
          owner_d[o]          = '0;
          gnt_d[owner_q[o]]   = 1'b0;
        end else if ((HOLD_LIMIT != 0) && (cnt_q[o] == HoldMax)) begin
          state_d[o]          = StIdle;
          owner_d[o]          = '0;
          gnt_d[owner_q[o]]   = 1'b0;
          timeout_d[o]        = 1'b1;
        end else if (HOLD_LIMIT != 0) begin
          cnt_d[o] = cnt_q[o] + CntW'(1);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        state_q[o] <= StIdle;
        owner_q[o] <= '0;
        ptr_q[o]   <= '0;
        cnt_q[o]   <= '0;
      end
      gnt_q     <= '0;
      timeout_q <= '0;
    end else begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        state_q[o] <= state_d[o];
        owner_q[o] <= owner_d[o];
        ptr_q[o]   <= ptr_d[o];
        cnt_q[o]   <= cnt_d[o];
      end
      gnt_q     <= gnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.timeout = timeout_q;

  always_comb begin
    bus.out_busy  = '0;
    bus.out_owner = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      bus.out_busy[o]                    = (state_q[o] == StOwned);
      bus.out_owner[o*ADDR_W +: ADDR_W]  = owner_q[o];
    end
  end

endmodule

// File: tb/tb_router_port_arbiter.sv
// Directed bench for router_port_arbiter: reset, single grant, round-robin order,
// full parallel grant, watchdog expiry, and mid-operation reset.
module tb_router_port_arbiter;
  localparam int unsigned N  = 16;
  localparam int unsigned AW = 4;
  localparam int unsigned HL = 8;

  logic clock = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  router_port_arbiter_if #(.NUM_PORTS(N), .ADDR_W(AW)) bus ();

  router_port_arbiter #(
    .NUM_PORTS (N),
    .ADDR_W    (AW),
    .HOLD_LIMIT(HL)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_da(input int i, input int d);
    bus.req_da[i*AW +: AW] = AW'(d);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".gnt"},     64'(bus.gnt),      64'h0);
    chk({tag, ".busy"},    64'(bus.out_busy), 64'h0);
    chk({tag, ".owner"},   bus.out_owner,     64'h0);
    chk({tag, ".timeout"}, 64'(bus.timeout),  64'h0);
  endtask

  logic [63:0] exp_owner;
  int          highs;
  logic        dropped;
  logic        early_to;
  int          order [4];

  initial begin
    reset      = 1'b1;
    bus.req    = '0;
    bus.req_da = '0;
    bus.rel    = '0;
    order      = '{2, 7, 12, 2};

    // 1: reset with random request traffic
    for (int c = 0; c < 3; c++) begin
      bus.req    = 16'($urandom);
      bus.req_da = {$urandom, $urandom};
      step();
      chk_idle("reset");
    end
    bus.req    = '0;
    bus.req_da = '0;
    reset      = 1'b0;
    step();
    chk_idle("post_reset");

    // 2: single request 3 -> 5, release after a few cycles
    bus.req[3] = 1'b1;
    set_da(3, 5);
    step();
    chk("single.gnt",   64'(bus.gnt),      64'h0008);
    chk("single.busy",  64'(bus.out_busy), 64'h0020);
    chk("single.owner", bus.out_owner,     64'h3 << 20);
    step();
    step();
    chk("single.hold",  64'(bus.gnt),      64'h0008);
    bus.rel[3] = 1'b1;
    bus.req[3] = 1'b0;
    step();
    bus.rel = '0;
    chk_idle("single.rel");

    // 3: round-robin contention on output 0
    reset = 1'b1;
    step();
    reset      = 1'b0;
    bus.req_da = '0;
    bus.req    = 16'h1084;
    step();
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("rr%0d.gnt", g),   64'(bus.gnt), 64'h1 << order[g]);
      chk($sformatf("rr%0d.owner", g), bus.out_owner, 64'(order[g]));
      step();
      step();
      chk($sformatf("rr%0d.busy", g),  64'(bus.out_busy), 64'h1);
      bus.rel[order[g]] = 1'b1;
      step();
      bus.rel = '0;
      chk($sformatf("rr%0d.gap", g),   64'(bus.out_busy), 64'h0);
      if (g == 3) bus.req = '0;
      step();
    end
    chk_idle("rr.end");

    // 4: every input to a distinct output in the same cycle
    exp_owner = '0;
    for (int i = 0; i < N; i++) begin
      set_da(i, 15 - i);
      exp_owner[i*AW +: AW] = AW'(15 - i);
    end
    bus.req = 16'hffff;
    step();
    chk("par.gnt",   64'(bus.gnt),      64'hffff);
    chk("par.busy",  64'(bus.out_busy), 64'hffff);
    chk("par.owner", bus.out_owner,     exp_owner);
    bus.req = '0;
    bus.rel = 16'hffff;
    step();
    bus.rel = '0;
    chk_idle("par.rel");

    // 5a: watchdog reclaims output 9 from input 1
    bus.req_da = '0;
    set_da(1, 9);
    bus.req[1] = 1'b1;
    step();
    bus.req[1] = 1'b0;
    highs    = 0;
    dropped  = 1'b0;
    early_to = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (!dropped) begin
        if (bus.gnt[1]) begin
          highs++;
          if (bus.timeout != '0) early_to = 1'b1;
          step();
        end else begin
          dropped = 1'b1;
          chk("wd.timeout_pulse", 64'(bus.timeout), 64'h0200);
        end
      end
    end
    chk("wd.dropped",  64'(dropped),  64'h1);
    chk("wd.highs",    64'(highs),    64'(HL));
    chk("wd.early_to", 64'(early_to), 64'h0);
    step();
    chk("wd.pulse_end", 64'(bus.timeout), 64'h0);
    chk("wd.gnt_off",   64'(bus.gnt),     64'h0);

    // 5b: release lands in the expiry cycle -> no timeout
    bus.req[1] = 1'b1;
    step();
    bus.req[1] = 1'b0;
    chk("wdrel.gnt", 64'(bus.gnt), 64'h0002);
    for (int c = 0; c < HL - 1; c++) step();
    chk("wdrel.still", 64'(bus.gnt), 64'h0002);
    bus.rel[1] = 1'b1;
    step();
    bus.rel = '0;
    chk_idle("wdrel.rel");
    step();
    chk("wdrel.no_to", 64'(bus.timeout), 64'h0);

    // 6: reset while four outputs are owned, then contention restarts from input 0
    bus.req_da = '0;
    set_da(3, 1);
    set_da(5, 4);
    set_da(8, 6);
    set_da(10, 11);
    bus.req = 16'h0528;
    step();
    bus.req = '0;
    chk("mid.gnt",  64'(bus.gnt),      64'h0528);
    chk("mid.busy", 64'(bus.out_busy), 64'h0852);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_idle("mid.reset");
    bus.req_da = '0;
    set_da(2, 1);
    set_da(6, 1);
    set_da(1, 4);
    set_da(7, 4);
    bus.req = 16'h00c6;
    step();
    bus.req = '0;
    chk("mid.ptr_gnt",   64'(bus.gnt),      64'h0006);
    chk("mid.ptr_owner", bus.out_owner,     (64'h1 << 16) | (64'h2 << 4));
    chk("mid.ptr_to",    64'(bus.timeout),  64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
